// File: rtl/cook_sequencer_pkg.sv
// Shared definitions for the microwave cook sequencer: state encoding and
// the key/power limits used by the controller.
package cook_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int MAX_DIGITS = 4;
  localparam int POWER_FULL = 10;

endpackage

// File: rtl/cook_duty_counter.sv
// Modulo-DUTY_PERIOD tick counter for magnetron power windowing; reports
// whether the count it is about to hold falls inside the power-on slice.
module cook_duty_counter #(
  parameter int DUTY_PERIOD = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       hold_i,
  input  logic       tick_i,
  input  logic [3:0] power_level_i,
  output logic       duty_en_o
);

  localparam int CW = (DUTY_PERIOD > 2) ? $clog2(DUTY_PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i && !hold_i) begin
      cnt_d = (cnt_q == CW'(DUTY_PERIOD - 1)) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare on the next count so the registered mag_on lines up with it.
  assign duty_en_o = (32'(cnt_d) < 32'(power_level_i));

endmodule

// File: rtl/cook_sequencer.sv
// Microwave operating FSM: digit entry, power selection, cook/pause/done
// sequencing, timer controls, duty-cycled magnetron enable and beeper.
module cook_sequencer
  import cook_sequencer_pkg::*;
#(
  parameter int BEEP_SECONDS = 3,
  parameter int DUTY_PERIOD  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       power_key,
  input  logic       start_pulse,
  input  logic       stop_pulse,
  input  logic       clear_pulse,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic       digit_load,
  output logic       timer_run,
  output logic       timer_clear,
  output logic       mag_on,
  output logic       beep,
  output logic [3:0] power_level,
  output logic [2:0] state
);

  localparam int BW = (BEEP_SECONDS > 1) ? $clog2(BEEP_SECONDS + 1) : 1;

  state_e        state_q, state_d;
  logic [2:0]    digit_cnt_q, digit_cnt_d;
  logic [3:0]    power_q, power_d;
  logic          armed_q, armed_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          digit_load_q, digit_load_d;
  logic          timer_clear_q, timer_clear_d;
  logic          timer_run_q, beep_q, mag_on_q;
  logic          duty_clear, duty_hold, duty_en;

  cook_duty_counter #(
    .DUTY_PERIOD(DUTY_PERIOD)
  ) u_duty (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (duty_clear),
    .hold_i       (duty_hold),
    .tick_i       (tick_1hz),
    .power_level_i(power_q),
    .duty_en_o    (duty_en)
  );

  always_comb begin
    state_d       = state_q;
    digit_cnt_d   = digit_cnt_q;
    power_d       = power_q;
    armed_d       = armed_q;
    beep_cnt_d    = beep_cnt_q;
    digit_load_d  = 1'b0;
    timer_clear_d = 1'b0;
    duty_clear    = 1'b0;
    duty_hold     = 1'b1;

    if (clear_pulse) begin
      state_d       = ST_IDLE;
      timer_clear_d = 1'b1;
      power_d       = 4'(POWER_FULL);
      digit_cnt_d   = '0;
      armed_d       = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_SET: begin
          if (state_q == ST_SET && start_pulse && door_closed && !timer_zero) begin
            state_d    = ST_COOK;
            duty_clear = 1'b1;
          end else if (power_key) begin
            armed_d = 1'b1;
          end else if (key_valid) begin
            if (armed_q) begin
              power_d = (key_digit == 4'd0) ? 4'(POWER_FULL) : key_digit;
              armed_d = 1'b0;
            end else if (digit_cnt_q < 3'(MAX_DIGITS)) begin
              digit_load_d = 1'b1;
              digit_cnt_d  = digit_cnt_q + 3'd1;
              state_d      = ST_SET;
            end
          end
        end
        ST_COOK: begin
          if (stop_pulse || !door_closed) begin
            state_d = ST_PAUSE;
          end else if (timer_zero) begin
            state_d    = ST_DONE;
            beep_cnt_d = '0;
          end else begin
            duty_hold = 1'b0;
          end
        end
        ST_PAUSE: begin
          if (stop_pulse) begin
            state_d       = ST_IDLE;
            timer_clear_d = 1'b1;
            digit_cnt_d   = '0;
          end else if (start_pulse && door_closed) begin
            state_d = ST_COOK;
          end else if (power_key) begin
            armed_d = 1'b1;
          end
        end
        ST_DONE: begin
          if (stop_pulse || !door_closed) begin
            state_d     = ST_IDLE;
            digit_cnt_d = '0;
          end else if (tick_1hz) begin
            if (beep_cnt_q == BW'(BEEP_SECONDS - 1)) begin
              state_d     = ST_IDLE;
              digit_cnt_d = '0;
            end else begin
              beep_cnt_d = beep_cnt_q + BW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      digit_cnt_q   <= '0;
      power_q       <= 4'(POWER_FULL);
      armed_q       <= 1'b0;
      beep_cnt_q    <= '0;
      digit_load_q  <= 1'b0;
      timer_clear_q <= 1'b0;
      timer_run_q   <= 1'b0;
      beep_q        <= 1'b0;
      mag_on_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_cnt_q   <= digit_cnt_d;
      power_q       <= power_d;
      armed_q       <= armed_d;
      beep_cnt_q    <= beep_cnt_d;
      digit_load_q  <= digit_load_d;
      timer_clear_q <= timer_clear_d;
      timer_run_q   <= (state_d == ST_COOK);
      beep_q        <= (state_d == ST_DONE);
      // Door level gates directly so an opening drops mag_on at the next edge.
      mag_on_q      <= (state_d == ST_COOK) && door_closed && duty_en;
    end
  end

  assign digit_load  = digit_load_q;
  assign timer_clear = timer_clear_q;
  assign timer_run   = timer_run_q;
  assign beep        = beep_q;
  assign mag_on      = mag_on_q;
  assign power_level = power_q;
  assign state       = state_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer: entry, duty cycling, pause/resume,
// beep timing, clear priority, digit limit and reset.
module tb_cook_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       power_key = 1'b0;
  logic       start_pulse = 1'b0;
  logic       stop_pulse = 1'b0;
  logic       clear_pulse = 1'b0;
  logic       door_closed = 1'b1;
  logic       timer_zero = 1'b1;
  logic       digit_load, timer_run, timer_clear, mag_on, beep;
  logic [3:0] power_level;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  cook_sequencer #(.BEEP_SECONDS(3), .DUTY_PERIOD(10)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .key_valid(key_valid),
    .key_digit(key_digit), .power_key(power_key), .start_pulse(start_pulse),
    .stop_pulse(stop_pulse), .clear_pulse(clear_pulse), .door_closed(door_closed),
    .timer_zero(timer_zero), .digit_load(digit_load), .timer_run(timer_run),
    .timer_clear(timer_clear), .mag_on(mag_on), .beep(beep),
    .power_level(power_level), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d; step(); key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (power_level !== 4'd10) begin errors++; $display("FAIL reset_power got %0d exp 10", power_level); end
    checks++;
    if ({digit_load, timer_run, timer_clear, mag_on, beep} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp 00000", {digit_load, timer_run, timer_clear, mag_on, beep});
    end
  endtask

  task automatic test_digits_start();
    int loads = 0;
    logic [3:0] keys [3] = '{4'd1, 4'd3, 4'd0};
    timer_zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      press_key(keys[i]);
      if (digit_load === 1'b1) loads++;
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL digit_state got %0d exp 1", state); end
      step();
      checks++; if (digit_load !== 1'b0) begin errors++; $display("FAIL digit_load_width got %b exp 0", digit_load); end
    end
    checks++; if (loads != 3) begin errors++; $display("FAIL digit_load_count got %0d exp 3", loads); end
    timer_zero = 1'b0;
    start_pulse = 1'b1; step(); start_pulse = 1'b0;
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL start_state got %0d exp 2", state); end
    checks++; if (timer_run !== 1'b1) begin errors++; $display("FAIL start_run got %b exp 1", timer_run); end
    checks++; if (mag_on !== 1'b1) begin errors++; $display("FAIL start_mag got %b exp 1", mag_on); end
    clear_pulse = 1'b1; step(); clear_pulse = 1'b0;
    checks++; if (timer_clear !== 1'b1 || state !== 3'd0) begin
      errors++; $display("FAIL clear_from_cook got clr=%b st=%0d exp clr=1 st=0", timer_clear, state);
    end
  endtask

  task automatic test_power_duty();
    int on_cnt = 0;
    timer_zero = 1'b1;
    power_key = 1'b1; step(); power_key = 1'b0;
    press_key(4'd3);
    checks++; if (digit_load !== 1'b0 || power_level !== 4'd3 || state !== 3'd0) begin
      errors++; $display("FAIL power_entry got ld=%b pwr=%0d st=%0d exp ld=0 pwr=3 st=0", digit_load, power_level, state);
    end
    press_key(4'd2); step();
    timer_zero = 1'b0;
    start_pulse = 1'b1; step(); start_pulse = 1'b0;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (mag_on !== ((k % 10) < 3)) begin
        errors++; $display("FAIL duty_tick%0d got %b exp %b", k, mag_on, (k % 10) < 3);
      end
      if (mag_on === 1'b1) on_cnt++;
      tick_1hz = 1'b1; step(); tick_1hz = 1'b0; step();
    end
    checks++; if (on_cnt != 6) begin errors++; $display("FAIL duty_total got %0d exp 6", on_cnt); end
  endtask

  task automatic test_door_pause();
    for (int k = 0; k < 2; k++) begin
      tick_1hz = 1'b1; step(); tick_1hz = 1'b0; step();
    end
    door_closed = 1'b0; step();
    checks++; if (state !== 3'd3 || mag_on !== 1'b0 || timer_run !== 1'b0) begin
      errors++; $display("FAIL door_open got st=%0d mag=%b run=%b exp st=3 mag=0 run=0", state, mag_on, timer_run);
    end
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0; step();
    door_closed = 1'b1; step();
    start_pulse = 1'b1; step(); start_pulse = 1'b0;
    checks++; if (state !== 3'd2 || mag_on !== 1'b1) begin
      errors++; $display("FAIL resume got st=%0d mag=%b exp st=2 mag=1", state, mag_on);
    end
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
    checks++; if (mag_on !== 1'b0) begin errors++; $display("FAIL resume_duty_held got %b exp 0", mag_on); end
  endtask

  task automatic test_done_beep();
    timer_zero = 1'b1; step();
    checks++; if (state !== 3'd4 || beep !== 1'b1 || timer_run !== 1'b0 || mag_on !== 1'b0) begin
      errors++; $display("FAIL done_entry got st=%0d beep=%b run=%b mag=%b exp 4 1 0 0", state, beep, timer_run, mag_on);
    end
    for (int t = 1; t <= 3; t++) begin
      tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
      checks++;
      if (beep !== (t < 3) || state !== ((t < 3) ? 3'd4 : 3'd0)) begin
        errors++; $display("FAIL beep_tick%0d got beep=%b st=%0d exp beep=%b", t, beep, state, t < 3);
      end
      step();
    end
    press_key(4'd4);
    timer_zero = 1'b0;
    start_pulse = 1'b1; step(); start_pulse = 1'b0;
    timer_zero = 1'b1; step();
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
    checks++; if (beep !== 1'b1) begin errors++; $display("FAIL beep_repeat got %b exp 1", beep); end
    stop_pulse = 1'b1; step(); stop_pulse = 1'b0;
    checks++; if (state !== 3'd0 || beep !== 1'b0) begin
      errors++; $display("FAIL beep_stop got st=%0d beep=%b exp st=0 beep=0", state, beep);
    end
  endtask

  task automatic test_clear_start();
    timer_zero = 1'b1;
    press_key(4'd5);
    power_key = 1'b1; step(); power_key = 1'b0;
    press_key(4'd7);
    checks++; if (power_level !== 4'd7) begin errors++; $display("FAIL power_set got %0d exp 7", power_level); end
    timer_zero = 1'b0;
    clear_pulse = 1'b1; start_pulse = 1'b1; step();
    clear_pulse = 1'b0; start_pulse = 1'b0;
    checks++; if (state !== 3'd0 || timer_clear !== 1'b1 || power_level !== 4'd10 || timer_run !== 1'b0) begin
      errors++; $display("FAIL clear_vs_start got st=%0d clr=%b pwr=%0d run=%b exp 0 1 10 0", state, timer_clear, power_level, timer_run);
    end
    step();
    checks++; if (timer_clear !== 1'b0 || state !== 3'd0) begin
      errors++; $display("FAIL clear_width got clr=%b st=%0d exp clr=0 st=0", timer_clear, state);
    end
  endtask

  task automatic test_digit_limit_reset();
    int loads = 0;
    timer_zero = 1'b1;
    for (int i = 0; i < 5; i++) begin
      press_key(4'(i + 1));
      if (digit_load === 1'b1) loads++;
      step();
    end
    checks++; if (loads != 4) begin errors++; $display("FAIL five_digits got %0d exp 4", loads); end
    timer_zero = 1'b0;
    door_closed = 1'b0;
    start_pulse = 1'b1; step(); start_pulse = 1'b0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL start_door_open got %0d exp 1", state); end
    door_closed = 1'b1;
    start_pulse = 1'b1; step(); start_pulse = 1'b0;
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL start_again got %0d exp 2", state); end
    rst = 1'b1; stop_pulse = 1'b1; step(); rst = 1'b0; stop_pulse = 1'b0;
    checks++;
    if (state !== 3'd0 || {digit_load, timer_run, timer_clear, mag_on, beep} !== 5'b0 || power_level !== 4'd10) begin
      errors++; $display("FAIL reset_mid_cook got st=%0d outs=%b pwr=%0d exp 0 00000 10", state,
                         {digit_load, timer_run, timer_clear, mag_on, beep}, power_level);
    end
  endtask

  initial begin
    test_reset();
    test_digits_start();
    test_power_duty();
    test_door_pause();
    test_done_beep();
    test_clear_start();
    test_digit_limit_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
